fp16_to_int: RTL and testbench

- Converts an IEEE 754 half-precision value into a two's-complement (or unsigned) integer of width INT_W.
- Unpacks the fp16 word and reverses the packing done by the fp16 arithmetic datapath. It sits at the boundary where fp16 results feed integer logic such as indexing, counters or fixed-point post-processing.
- Implemented as a 2-stage valid/ready pipeline with full backpressure, selectable rounding, and saturation with status flags.

---
 rtl/fp16_to_int.sv | 150 +++++++++++++++
 tb/tb_fp16_to_int.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_to_int.sv
// rtl/fp16_to_int.sv - fp16 to integer converter, 2-stage valid/ready pipeline
module fp16_to_int #(
    parameter int INT_W  = 16,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_rm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] out_data,
    output logic             out_invalid,
    output logic             out_inexact
);

    localparam logic [33:0] POS_LIM = SIGNED ? ((34'd1 << (INT_W - 1)) - 34'd1)
                                             : ((34'd1 << INT_W) - 34'd1);
    localparam logic [33:0] NEG_LIM = SIGNED ? (34'd1 << (INT_W - 1)) : 34'd0;
    localparam logic [INT_W-1:0] MAX_VAL = POS_LIM[INT_W-1:0];
    localparam logic [INT_W-1:0] MIN_VAL = SIGNED ? {1'b1, {(INT_W-1){1'b0}}}
                                                  : {INT_W{1'b0}};

    logic s1_valid;
    logic s1_sign, s1_rm, s1_nan, s1_inf, s1_zero, s1_ovf, s1_g, s1_st;
    logic [32:0] s1_int;

    logic s2_adv, s1_adv;
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = rst_n && s1_adv;

    // Stage 1 decode: aligned word holds 33 integer bits above a 12-bit fraction.
    logic [4:0]  exp_f;
    logic [9:0]  mant;
    logic [4:0]  shamt;
    logic [44:0] aligned;
    logic        d_nan, d_inf, d_zero, d_ovf, d_g, d_st;
    logic [32:0] d_int;

    assign exp_f   = in_data[14:10];
    assign mant    = in_data[9:0];
    assign shamt   = exp_f - 5'd15;
    assign aligned = {32'd0, 1'b1, mant, 2'b00} << shamt;

    always_comb begin
        d_nan  = 1'b0;
        d_inf  = 1'b0;
        d_zero = 1'b0;
        d_ovf  = 1'b0;
        d_g    = 1'b0;
        d_st   = 1'b0;
        d_int  = '0;
        if (exp_f == 5'd31) begin
            d_nan = |mant;
            d_inf = ~|mant;
        end else if (exp_f == 5'd0) begin
            d_zero = ~|mant;
            d_st   = |mant;
        end else if (exp_f < 5'd15) begin
            // Only exponent 14 (value in [0.5,1)) puts the hidden bit in the guard position.
            d_g  = (exp_f == 5'd14);
            d_st = (exp_f == 5'd14) ? |mant : 1'b1;
        end else if (int'(shamt) > INT_W) begin
            d_ovf = 1'b1;
        end else begin
            d_int = aligned[44:12];
            d_g   = aligned[11];
            d_st  = |aligned[10:0];
        end
    end

    // Stage 2 round, range check and pack.
    logic             rnd_inc;
    logic [33:0]      rounded;
    logic [INT_W-1:0] d2_data;
    logic             d2_inv, d2_inx;

    always_comb begin
        rnd_inc = s1_rm && s1_g && (s1_st || s1_int[0]);
        rounded = {1'b0, s1_int} + {33'd0, rnd_inc};
        d2_data = '0;
        d2_inv  = 1'b0;
        d2_inx  = 1'b0;
        if (s1_nan) begin
            d2_data = MAX_VAL;
            d2_inv  = 1'b1;
        end else if (s1_inf || s1_ovf) begin
            d2_data = s1_sign ? MIN_VAL : MAX_VAL;
            d2_inv  = 1'b1;
        end else if (s1_zero) begin
            d2_data = '0;
        end else if (!s1_sign) begin
            if (rounded > POS_LIM) begin
                d2_data = MAX_VAL;
                d2_inv  = 1'b1;
            end else begin
                d2_data = rounded[INT_W-1:0];
                d2_inx  = s1_g || s1_st;
            end
        end else if (rounded == 34'd0) begin
            d2_inx = s1_g || s1_st;
        end else if (rounded > NEG_LIM) begin
            d2_data = MIN_VAL;
            d2_inv  = 1'b1;
        end else begin
            d2_data = INT_W'(0) - rounded[INT_W-1:0];
            d2_inx  = s1_g || s1_st;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_invalid <= 1'b0;
            out_inexact <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data    <= d2_data;
                    out_invalid <= d2_inv;
                    out_inexact <= d2_inx;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            s1_sign <= in_data[15];
            s1_rm   <= in_rm;
            s1_nan  <= d_nan;
            s1_inf  <= d_inf;
            s1_zero <= d_zero;
            s1_ovf  <= d_ovf;
            s1_int  <= d_int;
            s1_g    <= d_g;
            s1_st   <= d_st;
        end
    end

endmodule

// File: tb/tb_fp16_to_int.sv
// tb/tb_fp16_to_int.sv - bench for fp16_to_int, signed and unsigned 16-bit instances
module tb_fp16_to_int;

    typedef struct {
        logic [15:0] din;
        logic        rm;
        logic [15:0] s_d;
        logic        s_iv;
        logic        s_ix;
        logic [15:0] u_d;
        logic        u_iv;
        logic        u_ix;
    } vec_t;

    typedef struct {
        vec_t v;
        int   acc_cyc;
        bit   chk_lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, in_rm, out_ready;
    logic [15:0] in_data;
    logic        rdy_s, rdy_u, ov_s, ov_u, iv_s, iv_u, ix_s, ix_u;
    logic [15:0] od_s, od_u;

    fp16_to_int #(.INT_W(16), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s),
        .in_data(in_data), .in_rm(in_rm), .out_valid(ov_s), .out_ready(out_ready),
        .out_data(od_s), .out_invalid(iv_s), .out_inexact(ix_s)
    );

    fp16_to_int #(.INT_W(16), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_u),
        .in_data(in_data), .in_rm(in_rm), .out_valid(ov_u), .out_ready(out_ready),
        .out_data(od_u), .out_invalid(iv_u), .out_inexact(ix_u)
    );

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   n_acc = 0;
    bit   lat_on = 1'b1;
    exp_t sb[$];
    vec_t vecs[26];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s", name);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && ov_s === 1'b1 && out_ready === 1'b1) begin
            check("valid_pair", {31'd0, ov_u}, 32'd1);
            if (sb.size() == 0) begin
                fail_now("unexpected_output");
            end else begin
                e = sb.pop_front();
                check($sformatf("s_data[%h]", e.v.din), {16'd0, od_s}, {16'd0, e.v.s_d});
                check($sformatf("s_inv[%h]", e.v.din), {31'd0, iv_s}, {31'd0, e.v.s_iv});
                check($sformatf("s_inx[%h]", e.v.din), {31'd0, ix_s}, {31'd0, e.v.s_ix});
                check($sformatf("u_data[%h]", e.v.din), {16'd0, od_u}, {16'd0, e.v.u_d});
                check($sformatf("u_inv[%h]", e.v.din), {31'd0, iv_u}, {31'd0, e.v.u_iv});
                check($sformatf("u_inx[%h]", e.v.din), {31'd0, ix_u}, {31'd0, e.v.u_ix});
                if (e.chk_lat)
                    check($sformatf("latency[%h]", e.v.din), cyc - e.acc_cyc, 32'd2);
            end
        end
    end

    task automatic send(input vec_t v, input int budget);
        exp_t e;
        bit   done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = v.din;
        in_rm    = v.rm;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            if (rdy_s === 1'b1) begin
                e.v       = v;
                e.acc_cyc = cyc;
                e.chk_lat = lat_on;
                sb.push_back(e);
                n_acc++;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) fail_now($sformatf("accept_timeout[%h]", v.din));
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget && sb.size() != 0; k++) @(posedge clk);
        #1;
        if (sb.size() != 0) fail_now($sformatf("drain_timeout left=%0d", sb.size()));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] held_s, held_u;
        bit          got;

        vecs[0]  = '{16'h3C00, 1'b0, 16'h0001, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[1]  = '{16'hC500, 1'b0, 16'hFFFB, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[3]  = '{16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[4]  = '{16'h3E00, 1'b0, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b1};
        vecs[5]  = '{16'h3E00, 1'b1, 16'h0002, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b1};
        vecs[6]  = '{16'h4100, 1'b1, 16'h0002, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b1};
        vecs[7]  = '{16'h3800, 1'b1, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1};
        vecs[8]  = '{16'h0001, 1'b1, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1};
        vecs[9]  = '{16'h7800, 1'b0, 16'h7FFF, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b0};
        vecs[10] = '{16'hF800, 1'b0, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[11] = '{16'h7C00, 1'b0, 16'h7FFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[12] = '{16'hFC00, 1'b0, 16'h8000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[13] = '{16'h7E00, 1'b0, 16'h7FFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[14] = '{16'hB400, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1};
        vecs[15] = '{16'h7BFF, 1'b0, 16'h7FFF, 1'b1, 1'b0, 16'hFFE0, 1'b0, 1'b0};
        vecs[16] = '{16'hBC00, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[17] = '{16'hBA00, 1'b1, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[18] = '{16'h4B00, 1'b1, 16'h000E, 1'b0, 1'b0, 16'h000E, 1'b0, 1'b0};
        vecs[19] = '{16'h3A00, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1};
        vecs[20] = '{16'h4170, 1'b1, 16'h0003, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b1};
        vecs[21] = '{16'hFBFF, 1'b0, 16'h8000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[22] = '{16'h7A00, 1'b0, 16'h7FFF, 1'b1, 1'b0, 16'hC000, 1'b0, 1'b0};
        vecs[23] = '{16'h77FF, 1'b1, 16'h7FF0, 1'b0, 1'b0, 16'h7FF0, 1'b0, 1'b0};
        vecs[24] = '{16'hFE01, 1'b1, 16'h7FFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[25] = '{16'h3BFF, 1'b1, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_rm = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {30'd0, ov_s, ov_u}, 32'd0);
        check("rst_out_data", {od_s, od_u}, 32'd0);
        check("rst_flags", {28'd0, iv_s, ix_s, iv_u, ix_u}, 32'd0);
        check("rst_in_ready", {30'd0, rdy_s, rdy_u}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Back-to-back table with out_ready held high: every result at latency 2.
        for (int i = 0; i < 26; i++) send(vecs[i], 20);
        drain(50);

        // Backpressure: two accepted, then a 3-cycle stall with stable outputs.
        lat_on = 1'b0;
        out_ready = 1'b0;
        n_acc = 0;
        fork
            begin
                send(vecs[0], 60);
                send(vecs[1], 60);
                send(vecs[18], 60);
                send(vecs[21], 60);
            end
            begin
                got = 1'b0;
                for (int k = 0; k < 20 && !got; k++) begin
                    @(posedge clk);
                    #2;
                    if (n_acc >= 2) got = 1'b1;
                end
                if (!got) fail_now("bp_fill_timeout");
                held_s = od_s;
                held_u = od_u;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("bp_in_ready", {31'd0, rdy_s}, 32'd0);
                    check("bp_out_valid", {31'd0, ov_s}, 32'd1);
                    check("bp_hold_s", {16'd0, od_s}, {16'd0, held_s});
                    check("bp_hold_u", {16'd0, od_u}, {16'd0, held_u});
                end
                check("bp_accepted", n_acc, 32'd2);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain(50);

        // Reset with two results in flight.
        lat_on = 1'b1;
        send(vecs[5], 20);
        send(vecs[6], 20);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_in_ready", {31'd0, rdy_s}, 32'd0);
        @(posedge clk);
        #1;
        sb.delete();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_mid_no_stale", {30'd0, ov_s, ov_u}, 32'd0);
        end
        @(posedge clk);
        #1;
        send(vecs[20], 20);
        drain(50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
